// File: rtl/mole_game_core.sv
// mole_game_core: whack-a-mole engine with tick divider, LFSR spawning,
// per-mole lifetimes, hit/miss scoring and a countdown game timer.
module mole_game_core #(
    parameter int          HOLES        = 9,
    parameter int          POS_W        = 4,
    parameter int          SCORE_W      = 8,
    parameter int          TICK_DIV     = 10_000_000,
    parameter int          GAME_TICKS   = 300,
    parameter int          MOLE_LIFE    = 10,
    parameter int          SPAWN_PERIOD = 5,
    parameter int          MAX_MOLES    = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_game,
    input  logic               hit_valid,
    input  logic [POS_W-1:0]   hit_pos,
    output logic [HOLES-1:0]   map,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [15:0]        time_left,
    output logic [1:0]         cur_state,
    output logic               hit_ok,
    output logic               en_music
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
    localparam int          DIV_W = $clog2(TICK_DIV);
    localparam int          SPW_W = $clog2(SPAWN_PERIOD + 1);
    localparam logic [31:0] SAT   = 32'((64'd1 << SCORE_W) - 64'd1);

    state_t                state, state_n;
    logic [DIV_W-1:0]      div_q, div_n;
    logic [SPW_W-1:0]      spc_q, spc_n;
    logic [HOLES-1:0][7:0] life_q, life_n;
    logic [HOLES-1:0]      map_n, hit_vec, exp_vec, spawn_vec, cand_vec;
    logic [SCORE_W-1:0]    score_n, misses_n;
    logic [15:0]           time_n, lfsr;
    logic [POS_W-1:0]      cand;
    logic [31:0]           score_sum, miss_sum;
    logic                  tick, last_tick, live_tick, start, spawn_try, hit_n;

    assign cur_state = state;
    assign en_music  = state == PLAY;

    always_comb begin
        tick      = state == PLAY && div_q == DIV_W'(TICK_DIV - 1);
        last_tick = tick && time_left == 16'd1;
        live_tick = tick && !last_tick;
        start     = start_game && state != PLAY;
        // out-of-range hit_pos shifts the one-hot off the end, so it is ignored
        hit_vec   = (state == PLAY && hit_valid && !last_tick) ? HOLES'(1) << hit_pos : '0;
        hit_n     = |(hit_vec & map);
        cand      = POS_W'(lfsr % 16'(HOLES));
        cand_vec  = HOLES'(1) << cand;
        spawn_try = live_tick && spc_q == SPW_W'(SPAWN_PERIOD - 1) && $countones(map) < MAX_MOLES;
        spawn_vec = spawn_try ? cand_vec & ~map & ~hit_vec : '0;
        exp_vec   = '0;
        life_n    = life_q;
        for (int i = 0; i < HOLES; i++) begin
            exp_vec[i] = live_tick && map[i] && life_q[i] == 8'd1;
            life_n[i]  = start ? 8'd0 : spawn_vec[i] ? 8'(MOLE_LIFE) : hit_vec[i] ? 8'd0 :
                         (tick && map[i]) ? life_q[i] - 8'd1 : life_q[i];
        end
        // a hit on an expiring mole scores, so its expiry is not a miss
        miss_sum  = 32'(misses) + 32'($countones(exp_vec & ~hit_vec)) + 32'(|hit_vec && !hit_n);
        score_sum = 32'(score) + 32'(hit_n);
        score_n   = start ? '0 : score_sum > SAT ? score : SCORE_W'(score_sum);
        misses_n  = start ? '0 : miss_sum > SAT ? SCORE_W'(SAT) : SCORE_W'(miss_sum);
        map_n     = (start || last_tick) ? '0 : (map & ~hit_vec & ~exp_vec) | spawn_vec;
        time_n    = start ? 16'(GAME_TICKS) : tick ? time_left - 16'd1 : time_left;
        div_n     = (state != PLAY || tick) ? '0 : div_q + DIV_W'(1);
        spc_n     = start ? '0 : !live_tick ? spc_q : spc_q == SPW_W'(SPAWN_PERIOD - 1) ? '0 : spc_q + SPW_W'(1);
        state_n   = start ? PLAY : last_tick ? OVER : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_q     <= '0;
            spc_q     <= '0;
            life_q    <= '0;
            map       <= '0;
            score     <= '0;
            misses    <= '0;
            time_left <= '0;
            hit_ok    <= 1'b0;
            lfsr      <= LFSR_SEED;
        end else begin
            state     <= state_n;
            div_q     <= div_n;
            spc_q     <= spc_n;
            life_q    <= life_n;
            map       <= map_n;
            score     <= score_n;
            misses    <= misses_n;
            time_left <= time_n;
            hit_ok    <= hit_n;
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
        end
    end
endmodule

// File: tb/tb_mole_game_core.sv
// tb_mole_game_core: directed game scenarios checked against a behavioural
// game model with TICK_DIV=4, GAME_TICKS=20, MOLE_LIFE=3, MAX_MOLES=2, SCORE_W=2.
module tb_mole_game_core;
    logic       clk = 1'b0, rst = 1'b1, start_game = 1'b0, hit_valid = 1'b0;
    logic [3:0] hit_pos = 4'd0;
    logic [8:0] map;
    logic [1:0] score, misses, cur_state;
    logic [15:0] time_left;
    logic       hit_ok, en_music;
    int total = 0, bad = 0, cyc = 0;
    logic [15:0] m_lfsr;
    logic [8:0]  m_map;
    int m_life[9];
    int m_score, m_miss, m_time, m_state, m_div;
    logic m_hok;

    always #5 clk = ~clk;

    mole_game_core #(
        .HOLES(9), .POS_W(4), .SCORE_W(2), .TICK_DIV(4), .GAME_TICKS(20),
        .MOLE_LIFE(3), .SPAWN_PERIOD(1), .MAX_MOLES(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .hit_valid(hit_valid),
        .hit_pos(hit_pos), .map(map), .score(score), .misses(misses),
        .time_left(time_left), .cur_state(cur_state), .hit_ok(hit_ok), .en_music(en_music)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_map = '0;
        foreach (m_life[i]) m_life[i] = 0;
        m_score = 0;
        m_miss = 0;
        m_time = 0;
        m_state = 0;
        m_div = 0;
        m_hok = 1'b0;
    endtask

    task automatic model_step(input logic sg, input logic hv, input logic [3:0] hp);
        logic tk, fin, hitin;
        logic [8:0] nmap;
        int add, cand;
        tk = m_state == 1 && m_div == 3;
        fin = tk && m_time == 1;
        cand = int'(m_lfsr % 16'd9);
        m_hok = 1'b0;
        if (m_state != 1 && sg) begin
            m_score = 0;
            m_miss = 0;
            m_map = '0;
            foreach (m_life[i]) m_life[i] = 0;
            m_time = 20;
            m_state = 1;
            m_div = 0;
        end else if (m_state == 1) begin
            m_div = tk ? 0 : m_div + 1;
            if (fin) begin
                m_state = 2;
                m_time = 0;
                m_map = '0;
            end else begin
                hitin = hv && hp < 4'd9;
                add = 0;
                nmap = m_map;
                if (tk) begin
                    m_time--;
                    for (int i = 0; i < 9; i++)
                        if (m_map[i]) begin
                            m_life[i]--;
                            if (m_life[i] == 0) begin
                                nmap[i] = 1'b0;
                                if (!(hitin && int'(hp) == i)) add++;
                            end
                        end
                end
                if (hitin) begin
                    if (m_map[hp]) begin
                        nmap[hp] = 1'b0;
                        m_life[hp] = 0;
                        m_score = (m_score < 3) ? m_score + 1 : 3;
                        m_hok = 1'b1;
                    end else add++;
                end
                if (tk && $countones(m_map) < 2 && !m_map[cand] && !(hitin && int'(hp) == cand)) begin
                    nmap[cand] = 1'b1;
                    m_life[cand] = 3;
                end
                m_map = nmap;
                m_miss = (m_miss + add > 3) ? 3 : m_miss + add;
            end
        end
        m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1;
    endtask

    task automatic step(input logic sg, input logic hv, input logic [3:0] hp);
        start_game = sg;
        hit_valid = hv;
        hit_pos = hp;
        model_step(sg, hv, hp);
        @(posedge clk);
        #1;
        cyc++;
        start_game = 1'b0;
        hit_valid = 1'b0;
        chk("map", 32'(map), 32'(m_map));
        chk("score", 32'(score), m_score);
        chk("misses", 32'(misses), m_miss);
        chk("time_left", 32'(time_left), m_time);
        chk("cur_state", 32'(cur_state), m_state);
        chk("hit_ok", 32'(hit_ok), 32'(m_hok));
        chk("en_music", 32'(en_music), 32'(m_state == 1));
        chk("max_moles", 32'($countones(map) <= 2), 1);
    endtask

    function automatic int first_up();
        for (int i = 0; i < 9; i++) if (m_map[i]) return i;
        return -1;
    endfunction

    function automatic int first_empty();
        for (int i = 0; i < 9; i++) if (!m_map[i]) return i;
        return -1;
    endfunction

    task automatic tick_free();
        if (m_state == 1 && m_div == 3) step(0, 0, 0);
    endtask

    task automatic wait_raised(output int idx);
        idx = first_up();
        for (int k = 0; k < 40 && idx < 0; k++) begin
            step(0, 0, 0);
            idx = first_up();
        end
        if (idx < 0) timeout("wait_raised");
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_map"}, 32'(map), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_misses"}, 32'(misses), 0);
        chk({tag, "_time"}, 32'(time_left), 0);
        chk({tag, "_state"}, 32'(cur_state), 0);
        chk({tag, "_hit_ok"}, 32'(hit_ok), 0);
        chk({tag, "_music"}, 32'(en_music), 0);
    endtask

    initial begin
        int idx, e, s, os, om, others, ot;
        logic [8:0] omap;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;
        step(1, 0, 0);
        chk("start_state", 32'(cur_state), 1);
        chk("start_time", 32'(time_left), 20);
        repeat (10) step(0, 0, 0);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        model_reset();
        #1;
        rst = 1'b0;
        step(1, 0, 0);
        s = cyc - 1;
        chk("restart_state", 32'(cur_state), 1);
        chk("restart_time", 32'(time_left), 20);
        wait_raised(idx);
        tick_free();
        idx = first_up();
        if (idx >= 0) begin
            os = m_score;
            step(0, 1, 4'(idx));
            chk("hit_score", 32'(score), os + 1);
            chk("hit_bit", 32'(map[idx]), 0);
            chk("hit_pulse", 32'(hit_ok), 1);
            step(0, 0, 0);
            chk("hit_pulse_end", 32'(hit_ok), 0);
        end else timeout("hit_target");
        tick_free();
        e = first_empty();
        om = m_miss;
        os = m_score;
        step(0, 1, 4'(e));
        chk("empty_miss", 32'(misses), om + 1);
        chk("empty_score", 32'(score), os);
        tick_free();
        omap = m_map;
        om = m_miss;
        os = m_score;
        step(0, 1, 4'd15);
        chk("pos15_map", 32'(map), 32'(omap));
        chk("pos15_score", 32'(score), os);
        chk("pos15_miss", 32'(misses), om);
        chk("pos15_hit_ok", 32'(hit_ok), 0);
        idx = -1;
        for (int k = 0; k < 60 && idx < 0; k++) begin
            if (m_state == 1 && m_div == 3 && m_time != 1)
                for (int i = 0; i < 9; i++) if (m_map[i] && m_life[i] == 1) idx = i;
            if (idx < 0) step(0, 0, 0);
        end
        if (idx >= 0) begin
            others = 0;
            for (int i = 0; i < 9; i++) if (i != idx && m_map[i] && m_life[i] == 1) others++;
            os = m_score;
            om = m_miss;
            step(0, 1, 4'(idx));
            chk("simul_score", 32'(score), os + 1);
            chk("simul_bit", 32'(map[idx]), 0);
            chk("simul_miss", 32'(misses), (om + others > 3) ? 3 : om + others);
        end else timeout("simul_find");
        while (cyc - s < 80) step(0, 0, 0);
        chk("end_pre_time", 32'(time_left), 1);
        chk("end_pre_state", 32'(cur_state), 1);
        step(0, 0, 0);
        chk("end_time", 32'(time_left), 0);
        chk("end_state", 32'(cur_state), 2);
        chk("end_map", 32'(map), 0);
        chk("end_music", 32'(en_music), 0);
        os = m_score;
        om = m_miss;
        step(0, 1, 4'd0);
        chk("over_score", 32'(score), os);
        chk("over_miss", 32'(misses), om);
        chk("over_state", 32'(cur_state), 2);
        step(1, 0, 0);
        chk("g2_score", 32'(score), 0);
        chk("g2_misses", 32'(misses), 0);
        chk("g2_state", 32'(cur_state), 1);
        chk("g2_time", 32'(time_left), 20);
        step(1, 0, 0);
        chk("ignore_start_time", 32'(time_left), 20);
        chk("ignore_start_state", 32'(cur_state), 1);
        for (int k = 0; k < 5; k++) begin
            wait_raised(idx);
            tick_free();
            idx = first_up();
            if (idx >= 0) step(0, 1, 4'(idx));
        end
        chk("sat_score", 32'(score), 3);
        for (int k = 0; k < 4; k++) begin
            tick_free();
            step(0, 1, 4'(first_empty()));
        end
        chk("sat_misses", 32'(misses), 3);
        for (int k = 0; k < 100 && m_state != 2; k++) step(0, 0, 0);
        chk("g2_end_state", 32'(cur_state), 2);
        chk("g2_end_score", 32'(score), 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
